freq_step_counter: RTL

Programmable-rate phase counter feeding the waveform processor of the frequency-selector experiment. It divides clk by a switch-selected prescale value and a power-of-two post-divider, and advances the 8-bit `count` phase that the waveform processor turns into rhomboid/square/saw/reciprocal outputs. New rate settings are captured on a load strobe and applied only at a phase wrap, so a running waveform never shows a partial period.

---
 rtl/freq_pkg.sv | 40 ++++
 rtl/freq_step_counter_if.sv | 40 ++++
 rtl/freq_prescaler.sv | 37 +++
 rtl/freq_step_counter.sv | 120 ++++++++++++
 4 files changed

// File: rtl/freq_pkg.sv
// freq_pkg: shared constants for the frequency-step counter
// default geometry, post-divider encodings and rate helpers
package freq_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_RESET_FREQ = 0;
  localparam logic [1:0] DEF_RESET_DIV = 2'd0;

  localparam logic [1:0] DIV1 = 2'd0;
  localparam logic [1:0] DIV2 = 2'd1;
  localparam logic [1:0] DIV4 = 2'd2;
  localparam logic [1:0] DIV8 = 2'd3;

  localparam int DIV_CNT_W = 3;

  // low bits of the post-divider counter that must all be set
  function automatic logic [DIV_CNT_W-1:0] div_mask(
    input logic [1:0] sel
  );
    logic [DIV_CNT_W-1:0] m;
    m = '0;
    unique case (sel)
      DIV1: m = 3'b000;
      DIV2: m = 3'b001;
      DIV4: m = 3'b011;
      DIV8: m = 3'b111;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  // clocks between steps for a given rate setting
  function automatic int unsigned step_period(
    input int unsigned freq,
    input logic [1:0] sel
  );
    return (freq + 32'd1) << sel;
  endfunction

endpackage

// File: rtl/freq_step_counter_if.sv
// freq_step_counter_if: rate control in, phase/status out
// master drives rate settings, slave is the counter
interface freq_step_counter_if
  import freq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             en;
  logic             ld;
  logic [WIDTH-1:0] freq_in;
  logic [1:0]       div_sel;
  logic [WIDTH-1:0] count;
  logic             tick;
  logic             wrap;
  logic             pending;

  modport master (
    output en,
    output ld,
    output freq_in,
    output div_sel,
    input  count,
    input  tick,
    input  wrap,
    input  pending
  );

  modport slave (
    input  en,
    input  ld,
    input  freq_in,
    input  div_sel,
    output count,
    output tick,
    output wrap,
    output pending
  );

endinterface

// File: rtl/freq_prescaler.sv
// freq_prescaler: reloadable down-counter, one stage event
// per (reload_val+1) enabled clocks; load forces a new phase
module freq_prescaler
  import freq_pkg::*;
#(
  parameter int           W       = DEF_WIDTH,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] reload_val,
  output logic         stage
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] pre_cnt;

  assign stage = en && (pre_cnt == '0);

  // load wins over reload; count holds while disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= RST_VAL;
    end else if (load) begin
      pre_cnt <= load_val;
    end else if (stage) begin
      pre_cnt <= reload_val;
    end else if (en) begin
      pre_cnt <= pre_cnt - ONE;
    end
  end

endmodule

// File: rtl/freq_step_counter.sv
// freq_step_counter: prescaled, post-divided phase counter
// rate changes are shadowed and only applied at a phase wrap
module freq_step_counter
  import freq_pkg::*;
#(
  parameter int               WIDTH      = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_FREQ = WIDTH'(DEF_RESET_FREQ),
  parameter logic [1:0]       RESET_DIV  = DEF_RESET_DIV
) (
  input logic                clk,
  input logic                rst,
  freq_step_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;
  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);
  localparam logic [DIV_CNT_W-1:0] DIV_ONE = DIV_CNT_W'(1);

  logic [WIDTH-1:0]     active_freq;
  logic [WIDTH-1:0]     shadow_freq;
  logic [1:0]           active_div;
  logic [1:0]           shadow_div;
  logic [DIV_CNT_W-1:0] div_cnt;
  logic [DIV_CNT_W-1:0] mask;
  logic [WIDTH-1:0]     count_q;
  logic                 tick_q;
  logic                 wrap_q;
  logic                 pending_q;
  logic                 stage;
  logic                 step;
  logic                 at_max;
  logic                 apply;

  freq_prescaler #(
    .W       (WIDTH),
    .RST_VAL (RESET_FREQ)
  ) u_pre (
    .clk        (clk),
    .rst        (rst),
    .en         (bus.en),
    .load       (apply),
    .load_val   (shadow_freq),
    .reload_val (active_freq),
    .stage      (stage)
  );

  // step/apply decode from current state
  always_comb begin
    mask   = div_mask(active_div);
    step   = stage && ((div_cnt & mask) == mask);
    at_max = (count_q == CNT_MAX);
    apply  = pending_q && ((step && at_max) || !bus.en);
  end

  // shadow capture on every load strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_freq <= '0;
      shadow_div  <= '0;
    end else if (bus.ld) begin
      shadow_freq <= bus.freq_in;
      shadow_div  <= bus.div_sel;
    end
  end

  // a load on the apply edge keeps the new value pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q <= 1'b0;
    end else if (bus.ld) begin
      pending_q <= 1'b1;
    end else if (apply) begin
      pending_q <= 1'b0;
    end
  end

  // active rate takes the pre-edge shadow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active_freq <= RESET_FREQ;
      active_div  <= RESET_DIV;
    end else if (apply) begin
      active_freq <= shadow_freq;
      active_div  <= shadow_div;
    end
  end

  // post-divider restarts with the new rate
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (apply) begin
      div_cnt <= '0;
    end else if (stage) begin
      div_cnt <= div_cnt + DIV_ONE;
    end
  end

  // phase advance with registered tick/wrap pulses
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end else if (step) begin
      count_q <= count_q + CNT_ONE;
      tick_q  <= 1'b1;
      wrap_q  <= at_max;
    end else begin
      tick_q  <= 1'b0;
      wrap_q  <= 1'b0;
    end
  end

  assign bus.count   = count_q;
  assign bus.tick    = tick_q;
  assign bus.wrap    = wrap_q;
  assign bus.pending = pending_q;

endmodule
